// File: rtl/star_bank.sv
// star_bank: bank of N_STARS collectible stars for the object layer.
// Each star has a fixed world position. An inclusive AABB overlap with the
// character collects an ACTIVE star. The bank also keeps a saturating score,
// emits a one-cycle collect event and supports a synchronous level clear.
// Optional feature macro: STAR_RESPAWN_EN. When it is defined, a collected
// star waits RESPAWN_CYCLES cycles and then respawns. When it is undefined,
// a collected star stays gone until reset or clear.
module star_bank #(
  parameter int unsigned               N_STARS        = 4,
  parameter logic [N_STARS*10-1:0]     STAR_X_INIT    = {10'd347, 10'd300, 10'd200, 10'd100},
  parameter logic [N_STARS*10-1:0]     STAR_Y_INIT    = {4{10'd56}},
  parameter int unsigned               STAR_W         = 12,
  parameter int unsigned               CHAR_W         = 12,
  parameter int unsigned               RESPAWN_CYCLES = 1000
) (
  input  logic                    sys_clk,
  input  logic                    RST_N,
  input  logic [9:0]              char_X,
  input  logic [9:0]              char_Y,
  input  logic [9:0]              bg_pos,
  input  logic                    clear,
  output logic [N_STARS*10-1:0]   star_x,
  output logic [N_STARS*10-1:0]   star_y,
  output logic [N_STARS-1:0]      en,
  output logic [N_STARS-1:0]      touch,
  output logic                    collect_pulse,
  output logic [3:0]              collect_idx,
  output logic [7:0]              star_count,
  output logic                    all_collected
);

`ifdef STAR_RESPAWN_EN
  typedef enum logic [1:0] {ACTIVE, GONE, WAIT} star_state_t;
  localparam int unsigned CNT_W = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;
  logic [CNT_W-1:0] cnt [N_STARS];
`else
  typedef enum logic [1:0] {ACTIVE, GONE} star_state_t;
`endif

  star_state_t        state [N_STARS];
  logic [N_STARS-1:0] overlap;
  logic [N_STARS-1:0] hit;
  logic [4:0]         hit_cnt;
  logic [3:0]         hit_idx;
  logic [8:0]         count_sum;
  logic [7:0]         count_next;

  logic [10:0] cx;
  logic [10:0] cy;
  assign cx = {1'b0, char_X};
  assign cy = {1'b0, char_Y};

  for (genvar g = 0; g < N_STARS; g++) begin : g_star
    localparam logic [9:0] SX = STAR_X_INIT[10*g +: 10];
    localparam logic [9:0] SY = STAR_Y_INIT[10*g +: 10];
    // Overlap is evaluated in 11 bits so that the box edges near 1023 cannot wrap.
    assign overlap[g] = (cx <= 11'(SX) + 11'(STAR_W)) && (cx + 11'(CHAR_W) >= 11'(SX)) &&
                        (cy <= 11'(SY) + 11'(STAR_W)) && (cy + 11'(CHAR_W) >= 11'(SY));
    assign star_x[10*g +: 10] = SX - bg_pos;
    assign star_y[10*g +: 10] = SY;
    assign en[g]              = (state[g] == ACTIVE);
  end

  assign hit = en & overlap;

  // Count this cycle's collections and find the lowest collected index.
  always_comb begin
    logic found;
    found   = 1'b0;
    hit_cnt = '0;
    hit_idx = '0;
    for (int unsigned i = 0; i < N_STARS; i++) begin
      if (hit[i]) begin
        hit_cnt = hit_cnt + 5'd1;
        if (!found) begin
          hit_idx = 4'(i);
          found   = 1'b1;
        end
      end
    end
    count_sum  = {1'b0, star_count} + 9'(hit_cnt);
    count_next = count_sum[8] ? 8'hFF : count_sum[7:0];
  end

  // Per-star state machines, score, event and all-collected flag.
  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < N_STARS; i++) begin
        state[i] <= ACTIVE;
`ifdef STAR_RESPAWN_EN
        cnt[i]   <= '0;
`endif
      end
      touch         <= '0;
      collect_pulse <= 1'b0;
      collect_idx   <= '0;
      star_count    <= '0;
      all_collected <= 1'b0;
    end else if (clear) begin
      for (int unsigned i = 0; i < N_STARS; i++) begin
        state[i] <= ACTIVE;
`ifdef STAR_RESPAWN_EN
        cnt[i]   <= '0;
`endif
      end
      touch         <= '0;
      collect_pulse <= 1'b0;
      star_count    <= '0;
      all_collected <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N_STARS; i++) begin
        case (state[i])
          ACTIVE: begin
            if (overlap[i]) begin
`ifdef STAR_RESPAWN_EN
              state[i] <= WAIT;
              cnt[i]   <= CNT_W'(RESPAWN_CYCLES - 1);
`else
              state[i] <= GONE;
`endif
              touch[i] <= 1'b1;
            end
          end
`ifdef STAR_RESPAWN_EN
          // The counter parks at zero while the character still overlaps the star.
          WAIT: begin
            if (cnt[i] == '0) begin
              if (!overlap[i]) state[i] <= ACTIVE;
            end else begin
              cnt[i] <= cnt[i] - 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
      collect_pulse <= |hit;
      if (|hit) collect_idx <= hit_idx;
      star_count    <= count_next;
      all_collected <= (en == '0) && (star_count != '0);
    end
  end

endmodule

// File: tb/tb_star_bank.sv
// Testbench for star_bank. A behavioural model pushes the expected outputs
// into a queue as each cycle's stimulus is driven. The expected outputs are
// popped and compared after the clock edge.
module tb_star_bank;

`ifdef STAR_RESPAWN_EN
  localparam bit RESP = 1'b1;
`else
  localparam bit RESP = 1'b0;
`endif
  localparam int R = 8;

  logic        sys_clk = 1'b0;
  logic        RST_N;
  logic [9:0]  char_X, char_Y, bg_pos, c2x, c2y;
  logic        clear;
  logic [39:0] star_x, star_y, star_x2, star_y2;
  logic [3:0]  en, touch, en2, touch2;
  logic        collect_pulse, pulse2, all_collected, all2;
  logic [3:0]  collect_idx, idx2;
  logic [7:0]  star_count, count2;

  always #5 sys_clk = ~sys_clk;

  star_bank #(.RESPAWN_CYCLES(R)) dut (
    .sys_clk(sys_clk), .RST_N(RST_N), .char_X(char_X), .char_Y(char_Y),
    .bg_pos(bg_pos), .clear(clear), .star_x(star_x), .star_y(star_y),
    .en(en), .touch(touch), .collect_pulse(collect_pulse),
    .collect_idx(collect_idx), .star_count(star_count),
    .all_collected(all_collected));

  star_bank #(.STAR_X_INIT({10'd347, 10'd150, 10'd150, 10'd100}), .RESPAWN_CYCLES(R)) dut2 (
    .sys_clk(sys_clk), .RST_N(RST_N), .char_X(c2x), .char_Y(c2y),
    .bg_pos(bg_pos), .clear(1'b0), .star_x(star_x2), .star_y(star_y2),
    .en(en2), .touch(touch2), .collect_pulse(pulse2),
    .collect_idx(idx2), .star_count(count2),
    .all_collected(all2));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0] en;
    logic [3:0] touch;
    logic       pulse;
    logic [3:0] idx;
    logic [7:0] count;
    logic       all;
  } exp_t;
  exp_t sb[$];

  // Model state: 0 = active, 1 = gone, 2 = waiting for respawn.
  int         sx [4] = '{100, 200, 300, 347};
  int         m_state [4];
  int         m_cnt [4];
  logic [3:0] m_touch;
  logic       m_pulse;
  logic [3:0] m_idx;
  int         m_count;
  logic       m_all;

  function automatic logic [3:0] model_en();
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = (m_state[i] == 0);
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_state[i] = 0; m_cnt[i] = 0; end
    m_touch = '0; m_pulse = 0; m_idx = '0; m_count = 0; m_all = 0;
    sb.delete();
  endtask

  task automatic model_next(input int cx, input int cy, input bit clr);
    logic [3:0] old_en;
    int n, first;
    bit ov;
    exp_t e;
    old_en = model_en();
    if (clr) begin
      for (int i = 0; i < 4; i++) begin m_state[i] = 0; m_cnt[i] = 0; end
      m_touch = '0; m_pulse = 0; m_count = 0; m_all = 0;
    end else begin
      m_all = (old_en == 4'b0000) && (m_count != 0);
      n = 0; first = -1;
      for (int i = 0; i < 4; i++) begin
        ov = (cx <= sx[i] + 12) && (cx + 12 >= sx[i]) && (cy <= 56 + 12) && (cy + 12 >= 56);
        if (m_state[i] == 0) begin
          if (ov) begin
            n++;
            if (first < 0) first = i;
            m_touch[i] = 1'b1;
            m_state[i] = RESP ? 2 : 1;
            m_cnt[i] = R - 1;
          end
        end else if (m_state[i] == 2) begin
          if (m_cnt[i] == 0) begin
            if (!ov) m_state[i] = 0;
          end else m_cnt[i]--;
        end
      end
      m_pulse = (n > 0);
      if (n > 0) m_idx = 4'(first);
      m_count = (m_count + n > 255) ? 255 : m_count + n;
    end
    e.en = model_en(); e.touch = m_touch; e.pulse = m_pulse;
    e.idx = m_idx; e.count = 8'(m_count); e.all = m_all;
    sb.push_back(e);
  endtask

  task automatic step(input int cx, input int cy, input bit clr, input string tag);
    exp_t e;
    char_X = 10'(cx); char_Y = 10'(cy); clear = clr;
    model_next(cx, cy, clr);
    @(posedge sys_clk); #1;
    e = sb.pop_front();
    check({tag, ".en"},    32'(en),            32'(e.en));
    check({tag, ".touch"}, 32'(touch),         32'(e.touch));
    check({tag, ".pulse"}, 32'(collect_pulse), 32'(e.pulse));
    check({tag, ".idx"},   32'(collect_idx),   32'(e.idx));
    check({tag, ".count"}, 32'(star_count),    32'(e.count));
    check({tag, ".all"},   32'(all_collected), 32'(e.all));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".en"},    32'(en),            32'hF);
    check({tag, ".touch"}, 32'(touch),         32'h0);
    check({tag, ".pulse"}, 32'(collect_pulse), 32'h0);
    check({tag, ".idx"},   32'(collect_idx),   32'h0);
    check({tag, ".count"}, 32'(star_count),    32'h0);
    check({tag, ".all"},   32'(all_collected), 32'h0);
  endtask

  initial begin
    int waited;
    RST_N = 1'b0; char_X = 10'd0; char_Y = 10'd200; bg_pos = 10'd0; clear = 1'b0;
    c2x = 10'd0; c2y = 10'd200;
    model_reset();
    #22;
    check_reset_values("reset");
    #3 RST_N = 1'b1;
    repeat (3) step(0, 200, 0, "far");

    // Two stars at the same position are collected on the same edge.
    c2x = 10'd150; c2y = 10'd56;
    step(0, 200, 0, "far2");
    check("dual.en",    32'(en2),    32'b1001);
    check("dual.count", 32'(count2), 32'd2);
    check("dual.idx",   32'(idx2),   32'd1);
    check("dual.pulse", 32'(pulse2), 32'd1);
    step(0, 200, 0, "far3");
    check("dual.pulse_end", 32'(pulse2), 32'd0);

    step(100, 56, 0, "hit0");
    repeat (10) step(100, 56, 0, "hold0");

    step(213, 56, 0, "x_plus13");
    step(212, 56, 0, "x_plus12");
    step(288, 56, 0, "x_minus12");
    step(347, 56, 0, "hit3");
    repeat (2) step(0, 200, 0, "idle");
    step(0, 200, 1, "clear");
    repeat (2) step(0, 200, 0, "post_clear");

    bg_pos = 10'd350; #1;
    check("scr.x3", 32'(star_x[39:30]), 32'd1021);
    check("scr.x0", 32'(star_x[9:0]),   32'd774);
    check("scr.y1", 32'(star_y[19:10]), 32'd56);
    bg_pos = 10'd0;

    // Asynchronous reset away from the clock edge.
    step(100, 56, 0, "pre_rst");
    #3 RST_N = 1'b0;
    #1 check_reset_values("async_rst");
    model_reset();
    #3 RST_N = 1'b1;
    step(0, 200, 0, "after_rst");

`ifdef STAR_RESPAWN_EN
    step(100, 56, 0, "rsp_hit");
    waited = 0;
    while (en[0] !== 1'b1 && waited < 20) begin
      step(0, 200, 0, "rsp_wait");
      waited++;
    end
    check("rsp_delay", 32'(waited), 32'(R));

    step(100, 56, 0, "stay_hit");
    repeat (12) step(100, 56, 0, "stay");
    check("stay.en0", 32'(en[0]), 32'd0);
    step(0, 200, 0, "leave");
    check("leave.en0", 32'(en[0]), 32'd1);

    for (int k = 0; k < 260; k++) begin
      step(100, 56, 0, "sat_hit");
      repeat (R) step(0, 200, 0, "sat_wait");
    end
    check("sat.count", 32'(star_count), 32'd255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/star_bank.md
# star_bank

Parametrised bank of N collectible stars for the game-calc object layer. It replaces the earlier one-star-per-module objects. Each star has a fixed world position, an AABB overlap test against the character, and per-star collected/enabled state. The bank adds a collection score counter, a one-cycle collect event, a synchronous level clear and an optional respawn timer. Outputs feed the renderer (screen-space coordinates, enable mask) and the score/HUD logic.

## Interface
Parameters:
- N_STARS, 4: number of stars, 1..16.
- STAR_X_INIT, {10'd347,10'd300,10'd200,10'd100}: packed N_STARS×10 world X. Star i is at bits [10i+9:10i].
- STAR_Y_INIT, {4{10'd56}}: packed N_STARS×10 world Y.
- STAR_W, 12: star box size in pixels, square.
- CHAR_W, 12: character box size in pixels, square.
- RESPAWN_CYCLES, 1000: respawn delay in sys_clk cycles, ≥1. Used only with STAR_RESPAWN_EN.

Ports:
- sys_clk  in  1  system clock.
- RST_N  in  1  reset, asynchronous, active-low.
- char_X  in  10  character world X.
- char_Y  in  10  character world Y.
- bg_pos  in  10  background scroll offset.
- clear  in  1  synchronous level restart: all stars ACTIVE, touch and count cleared.
- star_x  out  N_STARS×10  screen X per star = world X − bg_pos, mod 1024, combinational.
- star_y  out  N_STARS×10  screen Y per star = world Y.
- en  out  N_STARS  star visible/collectable.
- touch  out  N_STARS  sticky flag: star collected at least once since reset/clear.
- collect_pulse  out  1  high for one cycle on any collection.
- collect_idx  out  4  lowest index collected in the pulse cycle. Holds its value otherwise.
- star_count  out  8  total collections, saturating at 255.
- all_collected  out  1  registered; high when en == 0 and at least one collection has occurred.

## Operation
- Per-star FSM:
  - ACTIVE: en=1.
  - GONE: en=0.
  - WAIT: en=0, respawn countdown running. Exists only with the macro.
- Overlap for star i compares in 11-bit unsigned arithmetic, with no wrap:
  - char_X ≤ sx+STAR_W and char_X+CHAR_W ≥ sx, and
  - char_Y ≤ sy+STAR_W and char_Y+CHAR_W ≥ sy.
  - All bounds are inclusive. Coordinates are world coordinates; bg_pos does not enter the test.
- ACTIVE with overlap → GONE (or WAIT). At that edge: touch[i]←1, collect_pulse←1.
- Simultaneous collections: all overlapping ACTIVE stars leave ACTIVE on the same edge.
  - star_count += popcount of collected stars, saturating at 255.
  - collect_idx = lowest collected index.
- Non-ACTIVE stars never re-trigger a collection.
- clear=1: every star → ACTIVE, touch←0, star_count←0, collect_pulse←0, respawn counters←0. clear wins over any same-cycle collection or respawn.
- Reset values: en = all 1; touch = 0; collect_pulse = 0; collect_idx = 0; star_count = 0; all_collected = 0.

## Timing
- Overlap sampled at edge k. en[i] falls, touch[i] rises, collect_pulse is high and star_count updates, all after edge k (1-cycle latency).
- collect_pulse lasts exactly one cycle, even if overlap persists.
- all_collected goes high one cycle after the last en bit falls.
- star_x/star_y follow bg_pos combinationally (0 cycles). Example: world 5, bg_pos 10 → star_x 1019.
- Asynchronous RST_N assertion mid-countdown aborts immediately to reset values.
- Respawn: see Configuration. The expiry check happens on the cycle the counter reaches 0.

## Configuration
- STAR_RESPAWN_EN defined:
  - Collection enters WAIT with the counter loaded to RESPAWN_CYCLES−1.
  - The counter decrements each cycle. At 0 with no overlap, the star → ACTIVE and en rises on the next edge, RESPAWN_CYCLES cycles after it fell.
  - At 0 with overlap, the star holds in WAIT (counter stays 0) until the character leaves. This prevents instant re-collection.
  - touch stays 1 across respawn. all_collected drops when any star respawns.
- STAR_RESPAWN_EN undefined: collection enters GONE, which is terminal until RST_N or clear. No counter logic is synthesised.

## Test plan
- Reset with character far away (char 0,200) → en=4'b1111, touch=0, star_count=0, collect_pulse never high.
- Character at world (100,56), default params → one cycle later en[0]=0, touch[0]=1, collect_pulse=1 for one cycle, collect_idx=0, star_count=1. Hold position 10 cycles → no further pulse.
- Stars 1 and 2 moved to the same position, character on them → both en bits fall on the same edge, star_count +2, collect_idx=1.
- Collect all four stars, then pulse clear → all_collected 1 then 0. en=4'b1111, star_count=0, touch=0. Assert RST_N low mid-sequence → immediate reset values.
- Boundary: char_X = sx+12 (collects); char_X = sx+13 (no collect); char_X+12 = sx (collects). bg_pos=350 → star_x[3]=1021.
- With STAR_RESPAWN_EN and RESPAWN_CYCLES=8: collect, leave → en returns after exactly 8 cycles. Stay on the star → en stays 0 until leave, then rises the next cycle. star_count at 255 plus another collection → stays 255.
